// File: rtl/scoreboard_frame_rx.sv
// scoreboard_frame_rx
//   Receives 8N1 UART bytes on rx, groups them into frames delimited by idle
//   gaps, checks a mod-256 sum checksum and atomically publishes the payload.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rx           : asynchronous serial input, idles high
//   data         : last accepted payload, data[i] = payload byte i
//   frame_valid  : one-cycle pulse on the edge data updates
//   frame_err    : one-cycle pulse per rejected frame
module scoreboard_frame_rx #(
    parameter int CLKS_PER_BIT  = 104,
    parameter int IDLE_BITS     = 20,
    parameter int NUM_DATA_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data [NUM_DATA_BITS],
    output logic       frame_valid,
    output logic       frame_err
);
    localparam int HALF    = CLKS_PER_BIT / 2;
    localparam int CW      = $clog2(CLKS_PER_BIT);
    localparam int GAP_LIM = IDLE_BITS * CLKS_PER_BIT;
    localparam int GW      = $clog2(GAP_LIM + 1);
    localparam int IW      = $clog2(NUM_DATA_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_state_t;

    // input synchronizer plus one extra stage for falling-edge detection
    logic rx_meta, rx_sync, rx_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------- bit FSM ----------------
    bit_state_t      state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            bit_tick, stop_tick;
    logic            byte_done, ferr;

    always_comb begin
        state_nxt = state;
        bit_tick  = 1'b0;
        stop_tick = 1'b0;
        case (state)
            S_IDLE:  if (rx_prev && !rx_sync) state_nxt = S_START;
            S_START: if (cnt == CW'(HALF - 1))
                         state_nxt = rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                         bit_tick = 1'b1;
                         if (bit_idx == 3'd7) state_nxt = S_STOP;
                     end
            S_STOP:  if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                         stop_tick = 1'b1;
                         state_nxt = S_IDLE;
                     end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            byte_done <= 1'b0;
            ferr      <= 1'b0;
        end else begin
            state     <= state_nxt;
            byte_done <= stop_tick;
            // counter restarts on every state change so each phase times from zero
            if (state_nxt != state || state == S_IDLE)
                cnt <= '0;
            else
                cnt <= (cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt + 1'b1;
            if (state == S_START)
                bit_idx <= '0;
            if (bit_tick) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
                bit_idx   <= bit_idx + 1'b1;
            end
            if (stop_tick)
                ferr <= ~rx_sync;
        end
    end

    // ---------------- gap counter ----------------
    logic [GW-1:0] gap_cnt;
    logic          gap_run, gap;

    assign gap_run = (state == S_IDLE) && rx_sync;
    // fires only on the step into the limit, so once per idle period
    assign gap     = gap_run && (gap_cnt == GW'(GAP_LIM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gap_cnt <= '0;
        else if (!gap_run)
            gap_cnt <= '0;
        else if (gap_cnt != GW'(GAP_LIM))
            gap_cnt <= gap_cnt + 1'b1;
    end

    // ---------------- frame FSM ----------------
    logic [IW-1:0] idx;
    logic [7:0]    sum;
    logic          discard;
    logic [7:0]    shadow [NUM_DATA_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            sum         <= '0;
            discard     <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            for (int i = 0; i < NUM_DATA_BITS; i++) begin
                shadow[i] <= '0;
                data[i]   <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (gap) begin
                // a partially filled frame that was not already rejected is short
                if (idx != '0 && !discard) frame_err <= 1'b1;
                idx     <= '0;
                sum     <= '0;
                discard <= 1'b0;
            end else if (byte_done && !discard) begin
                if (ferr) begin
                    discard   <= 1'b1;
                    frame_err <= 1'b1;
                end else if (idx < IW'(NUM_DATA_BITS)) begin
                    shadow[idx] <= shift_reg;
                    sum         <= sum + shift_reg;
                    idx         <= idx + 1'b1;
                end else begin
                    if (shift_reg == sum) begin
                        data        <= shadow;
                        frame_valid <= 1'b1;
                    end else begin
                        frame_err   <= 1'b1;
                    end
                    discard <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_scoreboard_frame_rx.sv
module tb_scoreboard_frame_rx;
    localparam int CPB = 8;
    localparam int IB  = 20;
    localparam int ND  = 20;
    localparam int IDLE_CYC = 320;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dout [ND];
    logic       fv, fe;

    scoreboard_frame_rx #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IB), .NUM_DATA_BITS(ND)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .data(dout), .frame_valid(fv), .frame_err(fe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            v;
        logic [8*ND-1:0] p;
    } ev_t;

    ev_t             exp_q [$];
    logic [8*ND-1:0] exp_data = '0;
    int              total = 0;
    int              bad = 0;
    int              n_valid = 0;
    int              n_err = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [8*ND-1:0] act, input logic [8*ND-1:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [8*ND-1:0] pack_dout();
        logic [8*ND-1:0] p;
        for (int i = 0; i < ND; i++) p[8*i +: 8] = dout[i];
        return p;
    endfunction

    // Frame-level model: what one burst of bytes (followed by a gap) must yield.
    task automatic model_burst(input logic [7:0] b[$], input int bad_idx);
        ev_t  ev;
        logic [7:0] s;
        int   lim;
        if (b.size() == 0) return;
        lim = (b.size() < ND + 1) ? b.size() : ND + 1;
        for (int k = 0; k < lim; k++)
            if (k == bad_idx) begin
                ev.v = 1'b0; ev.p = '0; exp_q.push_back(ev); return;
            end
        if (b.size() < ND + 1) begin
            ev.v = 1'b0; ev.p = '0; exp_q.push_back(ev); return;
        end
        s = 8'd0;
        for (int k = 0; k < ND; k++) begin
            s += b[k];
            ev.p[8*k +: 8] = b[k];
        end
        ev.v = (b[ND] == s);
        exp_q.push_back(ev);
    endtask

    // compare process
    always @(negedge clk) begin
        ev_t e;
        if (rst_n) begin
            if (fv && fe) chk(0, "both_pulses", 1, 0);
            if (fv || fe) begin
                if (fv) n_valid++; else n_err++;
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_pulse", {fv, fe}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(fv == e.v, "pulse_kind", fv, e.v);
                    if (e.v) exp_data = e.p;
                    chk(pack_dout() == exp_data, "data_on_pulse", pack_dout(), exp_data);
                end
            end else begin
                chk(pack_dout() == exp_data, "data_stable", pack_dout(), exp_data);
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk); rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk); rx = stop_ok;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic send_burst(input logic [7:0] b[$], input int bad_idx);
        model_burst(b, bad_idx);
        for (int k = 0; k < b.size(); k++) send_byte(b[k], k != bad_idx);
        idle(IDLE_CYC);
        chk(exp_q.size() == 0, "events_drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_data = '0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] s;

        // reset state
        repeat (3) @(negedge clk);
        chk(pack_dout() == '0 && !fv && !fe, "reset_state", pack_dout(), '0);
        #1 rst_n = 1'b1;
        idle(IDLE_CYC);

        // good frame 0x00..0x13, checksum 0xBE
        q.delete();
        for (int i = 0; i < ND; i++) q.push_back(8'(i));
        q.push_back(8'hBE);
        send_burst(q, -1);
        chk(dout[5] == 8'h05 && dout[19] == 8'h13, "good_bytes", {dout[5], dout[19]}, 16'h0513);
        chk(n_valid == 1 && n_err == 0, "good_counts", {n_valid, n_err}, {32'd1, 32'd0});

        // bad checksum
        q[ND] = 8'hBF;
        send_burst(q, -1);
        chk(dout[19] == 8'h13, "badsum_keeps", dout[19], 8'h13);
        chk(n_valid == 1 && n_err == 1, "badsum_counts", {n_valid, n_err}, {32'd1, 32'd1});

        // framing error on byte 5, then good frame
        q[ND] = 8'hBE;
        send_burst(q, 5);
        chk(n_valid == 1 && n_err == 2, "ferr_counts", {n_valid, n_err}, {32'd1, 32'd2});
        send_burst(q, -1);
        chk(n_valid == 2 && n_err == 2, "after_ferr", {n_valid, n_err}, {32'd2, 32'd2});

        // short frame, then all-0xFF frame
        q.delete();
        for (int i = 0; i < 7; i++) q.push_back(8'(i + 1));
        send_burst(q, -1);
        chk(n_err == 3, "short_err", n_err, 3);
        q.delete();
        for (int i = 0; i < ND; i++) q.push_back(8'hFF);
        q.push_back(8'hEC);
        send_burst(q, -1);
        chk(dout[0] == 8'hFF && dout[19] == 8'hFF && n_valid == 3, "ff_frame",
            {dout[0], dout[19]}, 16'hFFFF);

        // false start glitch, then good frame with trailing byte
        @(negedge clk); rx = 1'b0;
        @(negedge clk);
        @(negedge clk); rx = 1'b1;
        idle(IDLE_CYC);
        chk(n_valid == 3 && n_err == 3, "glitch_quiet", {n_valid, n_err}, {32'd3, 32'd3});
        q.delete();
        for (int i = 0; i < ND; i++) q.push_back(8'(i));
        q.push_back(8'hBE);
        q.push_back(8'h55);
        send_burst(q, -1);
        chk(dout[0] == 8'h00 && dout[4] == 8'h04, "trailing_ignored", {dout[0], dout[4]}, 16'h0004);
        chk(n_valid == 4 && n_err == 3, "trailing_counts", {n_valid, n_err}, {32'd4, 32'd3});

        // reset during byte 10, then good frame immediately
        for (int k = 0; k < 10; k++) send_byte(q[k], 1'b1);
        @(negedge clk); rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        do_reset();
        @(negedge clk);
        chk(pack_dout() == '0, "reset_mid_frame", pack_dout(), '0);
        chk(n_valid == 4 && n_err == 3, "reset_no_pulse", {n_valid, n_err}, {32'd4, 32'd3});
        q.delete();
        s = 8'd0;
        for (int i = 0; i < ND; i++) begin
            q.push_back(8'(i + 8'h20));
            s += 8'(i + 8'h20);
        end
        q.push_back(s);
        send_burst(q, -1);
        chk(dout[3] == 8'h23 && n_valid == 5, "post_reset_frame", dout[3], 8'h23);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scoreboard_frame_rx.md
# scoreboard_frame_rx

Serial receiver that produces the 20-byte scoreboard state array consumed by the LED panel's segment decoder. It recovers 8N1 UART bytes from the `rx` line and delimits frames by idle gaps. Each frame is checked against a one-byte checksum. Only complete, valid frames are copied atomically into the output array, so the decoder never sees a partial update.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit. Must be ≥ 4.
- `IDLE_BITS`, default 20: idle-high bit-times that delimit frames.
- `NUM_DATA_BITS`, default 20: payload bytes per frame (the shared package constant).

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: asynchronous serial line; idles high.
- `data`, out, `[7:0] [NUM_DATA_BITS-1:0]` (unpacked): last accepted payload. `data[i]` is payload byte `i`.
- `frame_valid`, out, 1: one-cycle pulse when `data` updates.
- `frame_err`, out, 1: one-cycle pulse per rejected frame.

## Operation
- **Frame format:** `NUM_DATA_BITS` payload bytes, then 1 checksum byte. The checksum equals the 8-bit sum (mod 256) of the payload bytes. Frames are separated by ≥ `IDLE_BITS` bit-times of idle-high line.
- **Synchronizer:** `rx` passes through a 2-FF synchronizer. Both flops reset to 1.
- **Bit FSM:**
  - `IDLE`: a synced falling edge moves to `START`.
  - `START`: wait `CLKS_PER_BIT/2` cycles. Line still low → go to `DATA`. Line high → false start, return to `IDLE`; no byte, no error.
  - `DATA`: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first.
  - `STOP`: sample after `CLKS_PER_BIT` more cycles. Then emit `byte_done` with the byte and `ferr = ~stop_sample`, and return to `IDLE` immediately. The next start edge is accepted in the following cycle.
- **Gap counter:**
  - Counts cycles while the bit FSM is in `IDLE` and the synced `rx` is 1. Clears otherwise.
  - Saturates at `IDLE_BITS*CLKS_PER_BIT`.
  - Reaching the limit generates one `gap` event per idle period.
- **Frame FSM:** state is byte index `idx` (0..`NUM_DATA_BITS`), a `discard` flag, and an 8-bit running `sum`.
  - **`byte_done` with `discard`=1:** byte ignored, no pulse.
  - **`byte_done` with `ferr`=1:** set `discard` and pulse `frame_err`.
  - **`byte_done` with `idx < NUM_DATA_BITS`:** write the byte to `shadow[idx]`, add it to `sum`, increment `idx`.
  - **`byte_done` with `idx == NUM_DATA_BITS`:** this is the checksum byte; compare it to `sum`.
    - Match: copy `shadow` to `data` and pulse `frame_valid`.
    - Mismatch: pulse `frame_err` and leave `data` unchanged.
    - In both cases set `discard`, so bytes after the checksum are ignored silently until a gap.
  - **`gap`:**
    - If `idx` is in 1..`NUM_DATA_BITS` and `discard`=0 (short frame), pulse `frame_err`.
    - Always: `idx`←0, `sum`←0, `discard`←0.
- Arithmetic: `sum` is 8-bit wrap-around; `idx` needs 5 bits.

## Timing
- **Reset values:**
  - Outputs: `data` all 0x00 (decoder shows blank), `frame_valid`=0, `frame_err`=0.
  - Internal: synchronizer=1, bit FSM `IDLE`, `idx`=0, `sum`=0, `discard`=0, gap counter=0, `shadow` zeroed.
- **Reset mid-operation:** the in-progress byte and frame are abandoned; no pulse. A frame starting after `rst_n` deasserts is accepted without first needing a gap.
- **Input latency:** 2 cycles from `rx` pin to synced signal.
- **Byte completion:** `byte_done` is registered, one cycle after the stop-sample cycle.
- **Frame result:** `data` update and the `frame_valid` pulse, or `frame_err`, occur on the same edge, one cycle after `byte_done`. `data` is stable at all other times.
- **Pulse spacing:** at most one `frame_valid` or `frame_err` per byte or per gap. Pulses are never asserted together.
- **Gap vs. `byte_done`:** these cannot coincide, because the gap counter is cleared whenever the line is low.

## Test plan
Settings: `CLKS_PER_BIT`=8, `IDLE_BITS`=20.
- **Good frame:** payload 0x00..0x13, checksum 0xBE, then gap. Expect one `frame_valid`; `data[i]`=i; no `frame_err`.
- **Bad checksum:** same frame with checksum 0xBF. Expect one `frame_err`; `data` keeps its prior contents; no `frame_valid`.
- **Framing error:** stop bit forced 0 on byte 5. Expect `frame_err` at byte 5. The remaining bytes and checksum are ignored; no further pulses until the gap. A following good frame is accepted.
- **Short frame:** 7 bytes, then gap. Expect `frame_err` on the gap; `idx` resets. A following good frame (bytes 0xFF×20, checksum 0xEC) yields `data` all 0xFF.
- **False start and trailing byte:** a 2-cycle low glitch produces no byte and no pulse. A byte after the checksum but before the gap is ignored silently.
- **Reset mid-frame:** assert `rst_n`=0 during byte 10. Expect `data` 0x00 and no pulses. A full good frame immediately after reset is accepted.
